// File: rtl/main_memory_ctrl_pkg.sv
// Shared types and constants for the main-memory controller.
package main_memory_ctrl_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACKN = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // A word access is misaligned when either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/main_memory_ctrl_ram.sv
// Single-port synchronous word RAM with registered read data.
module main_memory_ram #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 10,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // Array write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read data register holds its value until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory port: fixed wait-state access FSM in front of a word RAM.
module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned WAIT_STATES   = 2,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic                     MEMCTRL_CLOCK_50,
  input  logic                     MEMCTRL_ResetInLow_In,
  input  logic                     MEMCTRL_RD_In,
  input  logic                     MEMCTRL_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_Address_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_DataWrite_InBus,
  output logic [DATAWIDTH_BUS-1:0] MEMCTRL_DataRead_OutBus,
  output logic                     MEMCTRL_ACK_Out,
  output logic                     MEMCTRL_Busy_Out,
  output logic                     MEMCTRL_Error_Out
);

  logic clk, rst_n;
  assign clk   = MEMCTRL_CLOCK_50;
  assign rst_n = MEMCTRL_ResetInLow_In;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MEM_ADDR_BITS-1:0] idx_q, idx_c;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_c;
  op_e                      op_q, op_c;
  logic                     misal_q, misal_c;
  logic                     err_q, err_d;
  logic                     ack_q;
  logic                     accept_c, access_c;
  logic                     ram_we_c, ram_re_c;

  // Address bits above the word index wrap and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^MEMCTRL_Address_InBus[DATAWIDTH_BUS-1:MEM_ADDR_BITS+2];

  // Next-state, request capture and error-flag update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    accept_c = 1'b0;
    idx_c    = idx_q;
    wdata_c  = wdata_q;
    op_c     = op_q;
    misal_c  = misal_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_c   = MEMCTRL_Address_InBus[MEM_ADDR_BITS+1:2];
        wdata_c = MEMCTRL_DataWrite_InBus;
        op_c    = MEMCTRL_WR_In ? OP_WRITE : OP_READ;
        misal_c = is_misaligned(MEMCTRL_Address_InBus[1:0]);
        if (MEMCTRL_RD_In || MEMCTRL_WR_In) begin
          accept_c = 1'b1;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = (WAIT_STATES == 0) ? ST_ACKN : ST_WAIT;
          if (!misal_c) err_d = 1'b0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_ACKN;
      end
      ST_ACKN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The array is touched on the edge that enters ACKN.
    access_c = (state_d == ST_ACKN);
    if (access_c && misal_c) err_d = 1'b1;
  end

  // Write strobe is gated by reset so an interrupted access never commits.
  assign ram_we_c = access_c && (op_c == OP_WRITE) && rst_n;
  assign ram_re_c = access_c && (op_c == OP_READ);

  // State, counter, flags and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= access_c;
      if (accept_c) begin
        idx_q   <= idx_c;
        wdata_q <= wdata_c;
        op_q    <= op_c;
        misal_q <= misal_c;
      end
    end
  end

  main_memory_ram #(
    .DATA_W       (DATAWIDTH_BUS),
    .ADDR_W       (MEM_ADDR_BITS),
    .MEM_INIT_FILE(MEM_INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we_c),
    .re_i   (ram_re_c),
    .addr_i (idx_c),
    .wdata_i(wdata_c),
    .rdata_o(MEMCTRL_DataRead_OutBus)
  );

  assign MEMCTRL_ACK_Out   = ack_q;
  assign MEMCTRL_Busy_Out  = (state_q != ST_IDLE);
  assign MEMCTRL_Error_Out = err_q;

endmodule
